uart_rx: RTL
============

# uart_rx

UART receiver: recovers bytes from the asynchronous serial line `rx_in` using a 16x oversampling tick derived from `sys_clk`, and presents each byte on a one-cycle `rx_valid` strobe. It is the receive-side counterpart of the Tx path and uses the same `SYS_CLK_FREQ`/`BAUD_RATE` parameter pair so both ends agree on bit time. Frame format is 1 start bit, `DATA_BITS` data bits sent LSB first, an optional parity bit, and 1 stop bit.

## Interface
- `SYS_CLK_FREQ`, 200_000_000: `sys_clk` frequency in Hz.
- `BAUD_RATE`, 19200: line baud rate.
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `PARITY_ODD`, 0: selects parity sense. 0 = even, 1 = odd. Only used when parity is compiled in.

- `sys_clk`  input  1: system clock, rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `rx_in`  input  1: serial line, asynchronous to `sys_clk`, idles high.
- `rx_data`  output  DATA_BITS: last received byte. Holds its value until the next byte is accepted.
- `rx_valid`  output  1: one-cycle strobe; `rx_data` is new.
- `frame_err`  output  1: one-cycle strobe; the stop bit sampled 0.
- `parity_err`  output  1: one-cycle strobe, coincident with `rx_valid`; parity mismatch.
- `rx_busy`  output  1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rx_in` passes through 2 flops, both reset to 1, producing `rx_s`. One further flop produces `rx_s_d`, used for falling-edge detection.
- **Tick generator:** a free-running counter, cleared on reset. DIV = SYS_CLK_FREQ / (BAUD_RATE*16), integer truncation. It emits a one-cycle `tick` when the count reaches DIV-1, then wraps to 0. Counter width is `$clog2(DIV)`.
- **tick_cnt:** a 4-bit counter that increments on each `tick` and wraps 15→0.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge (`rx_s_d`=1, `rx_s`=0), clear `tick_cnt` and go to START. A low line with no falling edge, such as a break, never starts a frame.
  - START: when `tick_cnt` reaches 7 on a tick (start-bit middle), sample `rx_s`.
    - `rx_s`=1: treat as a glitch and return to IDLE.
    - `rx_s`=0: clear `tick_cnt` and `bit_cnt`, go to DATA.
  - DATA: on each tick with `tick_cnt`=15, shift `rx_s` into the MSB of the shift register, shifting right, and increment `bit_cnt`. After the `DATA_BITS`-th sample, go to PARITY if parity is compiled in, otherwise go to STOP.
  - PARITY: sample at `tick_cnt`=15. Compute the error bit as the XOR of the data bits and the parity bit, XOR `PARITY_ODD`. Then go to STOP.
  - STOP: sample at `tick_cnt`=15, then return to IDLE.
    - `rx_s`=1: load `rx_data`, pulse `rx_valid`, and pulse `parity_err` if the error bit is set.
    - `rx_s`=0: pulse `frame_err` only. `rx_data` is unchanged and `rx_valid` is not asserted.
- **Back-to-back frames:** the stop sample occurs mid-bit, so the next start edge is always detected in IDLE. No idle gap is needed between frames.

## Timing
- **Reset:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0. State = IDLE, counters = 0, synchronizer flops = 1.
- **Reset mid-frame:** takes effect immediately. The partial byte is discarded and no strobe is emitted.
- **Edge detection:** `rx_busy` rises 3 `sys_clk` cycles after the `rx_in` falling edge (2 synchronizer flops plus the FSM register).
- **Strobes:** all three strobes are registered and assert on the cycle after the sampling tick. Each lasts exactly 1 cycle.
- **Frame latency:** edge to `rx_valid` is about (1 + DATA_BITS + P + 0.5) bit times, where P = 1 with parity and 0 without. Sample-phase jitter is ≤ 1/16 bit plus DIV cycles.
- **Baud accuracy:** combined Tx/Rx baud error of up to ±3% must be tolerated.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, the frame carries a parity bit, and `parity_err` is driven as described in Operation.
- `UART_RX_PARITY_EN` undefined: the PARITY state and parity logic are removed, the frame has no parity bit, and `parity_err` is tied to 0.

## Structure
- **Package `uart_pkg`:**
  - `OVERSAMPLE` = 16.
  - `rx_state_t` enum for IDLE/START/DATA/PARITY/STOP.
  - A function computing DIV from `SYS_CLK_FREQ` and `BAUD_RATE`.
- **Sub-module `uart_rx_tick_gen`:** generates the oversample tick. Ports are `sys_clk`, `reset_n`, `tick`; parameters are `SYS_CLK_FREQ` and `BAUD_RATE`.

## Test plan
Bench parameters for all scenarios: SYS_CLK_FREQ=1_600_000, BAUD_RATE=10_000, giving DIV=10 and one bit = 160 cycles.
1. Send 0xA5 with stop bit 1 → exactly one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0, `rx_busy` returns to 0.
2. Drive `rx_in` low for 40 cycles, then high → no strobes; `rx_busy` drops within 1 cycle after the start-middle sample.
3. Send 0x3C with stop bit 0, then hold the line low for 5 bit times → one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, no new frame until the line rises and falls again.
4. Send 0x00 then 0xFF back-to-back with no idle gap → two `rx_valid` pulses, data 0x00 then 0xFF.
5. Pulse `reset_n` low during data bit 4 of 0x77, then send 0x5A → no strobe for 0x77; outputs are 0 during reset; 0x5A is received correctly.
6. With `UART_RX_PARITY_EN` and `PARITY_ODD`=0:
   - Send 0x07 with parity bit 0 → `rx_valid`=1 with `parity_err`=1.
   - Send 0x07 with parity bit 1 → `rx_valid`=1 with `parity_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state type and divider helper for the UART receiver
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // System clocks per oversample tick, truncated toward zero.
   function automatic int calc_div(input int sys_clk_freq, input int baud_rate);
      return sys_clk_freq / (baud_rate * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - free-running 16x baud oversample tick generator
module uart_rx_tick_gen
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FREQ = 200_000_000,
   parameter int BAUD_RATE    = 19200
) (
   input  logic sys_clk,
   input  logic reset_n,
   output logic tick
);

   localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] div_cnt;

   assign tick = (div_cnt == CW'(DIV - 1));

   // Count sys_clk cycles, wrapping to 0 on the cycle the tick fires.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 16x oversampled; parity compiled in by UART_RX_PARITY_EN
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FREQ = 200_000_000,
   parameter int BAUD_RATE    = 19200,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 rx_busy
);

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AFTER_DATA = PARITY;
`else
   localparam rx_state_t AFTER_DATA = STOP;
`endif
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic                 rx_meta, rx_s, rx_s_d;
   logic                 tick;
   logic [3:0]           tick_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   rx_state_t            state, state_next;
   logic                 clr_tick, clr_bit, do_shift, do_par, stop_ok, stop_bad;

   uart_rx_tick_gen #(
      .SYS_CLK_FREQ (SYS_CLK_FREQ),
      .BAUD_RATE    (BAUD_RATE)
   ) u_tick_gen (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   assign rx_busy = (state != IDLE);

   // Two-flop synchronizer plus one delay flop for falling-edge detection; idle-high reset.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   // State register.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-cycle datapath controls; samples land mid-bit on tick boundaries.
   always_comb begin
      state_next = state;
      clr_tick   = 1'b0;
      clr_bit    = 1'b0;
      do_shift   = 1'b0;
      do_par     = 1'b0;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (rx_s_d && !rx_s) begin
               clr_tick   = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (tick && tick_cnt == 4'd7) begin
               if (rx_s) begin
                  state_next = IDLE;
               end else begin
                  clr_tick   = 1'b1;
                  clr_bit    = 1'b1;
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (tick && tick_cnt == 4'd15) begin
               do_shift = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_next = AFTER_DATA;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick && tick_cnt == 4'd15) begin
               do_par     = 1'b1;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (tick && tick_cnt == 4'd15) begin
               stop_ok    = rx_s;
               stop_bad   = !rx_s;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Oversample phase counter, bit counter and LSB-first shift register.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= '0;
      end else begin
         if (clr_tick) begin
            tick_cnt <= 4'd0;
         end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
         end
         if (clr_bit) begin
            bit_cnt <= 3'd0;
         end else if (do_shift) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (do_shift) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
         end
      end
   end

   // Registered output strobes; rx_data only changes on a good stop bit.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= stop_ok;
         frame_err <= stop_bad;
         if (stop_ok) begin
            rx_data <= shift_reg;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad;

   // Latch the parity check result and report it alongside rx_valid.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (do_par) begin
            par_bad <= (^shift_reg) ^ rx_s ^ (PARITY_ODD != 0);
         end
         parity_err <= stop_ok & par_bad;
      end
   end
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = (PARITY_ODD != 0) | do_par;
   assign parity_err        = 1'b0;
`endif

endmodule
